gsim_solver_param: RTL and testbench
====================================

// Module: gsim_solver_param
// PURPOSE
// Parametrised Gauss-Seidel solver for the banded Toeplitz system A*x = b.
// A has 20 on the diagonal, -13 at distance 1, +6 at distance 2 and -1 at distance 3.
// Successor to the fixed 16-unknown GSIM engine. Generalised in N, data widths and
// iteration limit. Adds tolerance-based convergence, back-to-back problem handling
// and status outputs.
// Sits between the b-vector stream source and the x-vector consumer.
// PARAMETERS
// N           16  number of unknowns (4..64)
// B_W         16  signed width of b_in
// FRAC        16  fractional bits of x (x = b<<FRAC initially)
// X_W         32  signed width of x_out (X_W >= B_W+FRAC)
// MAX_ITER    80  hard sweep limit (1..255)
// TOL         0   convergence tolerance, |x_new-x_old| <= TOL in LSBs
// CONV_SWEEPS 2   consecutive converged sweeps required to stop early
// PORTS
// clk        in   1      rising-edge clock
// reset      in   1      synchronous, active-high
// in_en      in   1      b_in valid strobe
// b_in       in   B_W    signed b element, index order 0..N-1
// busy       out  1      high in SWEEP/CHECK/OUTPUT; in_en ignored while high
// out_valid  out  1      x_out valid
// x_out      out  X_W    signed x element, index order 0..N-1
// converged  out  1      1 = stopped on tolerance, 0 = stopped on MAX_ITER; valid with out_valid
// iter_cnt   out  8      sweeps executed; valid with out_valid
// BEHAVIOUR
// - One clock; reset is synchronous and active-high.
// - Reset: state IDLE, load index 0, x[]/b[] cleared.
// - Reset values: busy=0, out_valid=0, x_out=0, converged=0, iter_cnt=0.
// - Reset mid-operation aborts the solve. The next in_en loads index 0.
// - States: IDLE -> SWEEP -> CHECK -> (SWEEP | OUTPUT) -> IDLE.
// - IDLE: each cycle with in_en=1 stores b[idx]=b_in and x[idx]=b_in<<<FRAC, then idx++.
//   Gaps in in_en are allowed; idx holds during gaps.
//   The cycle after the N-th sample enters SWEEP.
// - SWEEP: exactly N cycles, unknown i updated in cycle i (in-place, so x[0..i-1] are new values):
//   s_i = (b_i<<<FRAC) + 13(x[i-1]+x[i+1]) - 6(x[i-2]+x[i+2]) + (x[i-3]+x[i+3]).
//   Out-of-range indices contribute 0.
//   Compute s_i at full width (X_W+6 bits, no overflow).
//   x_new = floor(s_i/20), saturated to signed X_W.
//   Division is bit-exact floor; a reciprocal multiply is allowed only if bit-exact.
//   Track sweep_ok = AND over i of |x_new - x_old| <= TOL.
// - CHECK: 1 cycle. iter++.
//   conv_run = sweep_ok ? conv_run+1 : 0.
//   If conv_run_next == CONV_SWEEPS: converged=1, go to OUTPUT.
//   Else if iter_next == MAX_ITER: converged=0, go to OUTPUT.
//   Else go to SWEEP. Tolerance wins if both are true in the same CHECK.
// - Sweep period is N+1 cycles.
//   Latency from last in_en to first out_valid = iter_cnt*(N+1)+1 cycles.
// - OUTPUT: out_valid=1 for exactly N consecutive cycles, x_out = x[0]..x[N-1].
//   converged/iter_cnt are held stable during these cycles; no backpressure.
//   Then IDLE with out_valid=0.
// - converged/iter_cnt keep their values in IDLE until the next CHECK.
// - in_en during busy=1 is dropped, not buffered.
//   in_en in the last OUTPUT cycle is also dropped. The first accepted cycle is in IDLE.
// - iter and conv_run clear on entry to SWEEP from IDLE.
// TESTING
// 1. N=16, b all 0 -> 16 outputs =0, converged=1, iter_cnt=2, first out_valid 2*17+1 cycles after last in_en.
// 2. N=16, b_i=i*100-800 -> x_out bit-exact vs C golden (floor/saturate model), converged=1, iter_cnt<80.
// 3. MAX_ITER=3, TOL=0, b alternating +/-32767 -> converged=0, iter_cnt=3, outputs match golden after 3 sweeps.
// 4. Same b as test 2 with 3-cycle in_en gaps after samples 4 and 11 -> output identical to test 2.
// 5. reset asserted in sweep 5, then new b (test 2) -> result identical to a clean run; no stale out_valid.
// 6. N=8, X_W=24, FRAC=8, TOL=2 -> golden match; in_en pulses during OUTPUT ignored; next problem solves correctly.

Source files
------------

// File: rtl/gsim_solver_param.sv
// rtl/gsim_solver_param.sv - parametrised Gauss-Seidel solver for a banded Toeplitz system
//
// Solves A*x = b where A has 20 on the diagonal, -13 at distance 1, +6 at
// distance 2 and -1 at distance 3. b arrives as a strobed element stream,
// x leaves as a valid-qualified element stream after the iteration stops
// on tolerance or on the sweep limit.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high
//   in_en      in   b_in valid strobe (only honoured while idle)
//   b_in       in   signed b element, index order 0..N-1
//   busy       out  high while sweeping, checking or emitting results
//   out_valid  out  x_out valid
//   x_out      out  signed x element, index order 0..N-1
//   converged  out  1 = stopped on tolerance, 0 = stopped on sweep limit
//   iter_cnt   out  number of sweeps executed
module gsim_solver_param #(
  parameter int N           = 16,
  parameter int B_W         = 16,
  parameter int FRAC        = 16,
  parameter int X_W         = 32,
  parameter int MAX_ITER    = 80,
  parameter int TOL         = 0,
  parameter int CONV_SWEEPS = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_en,
  input  logic signed [B_W-1:0] b_in,
  output logic                  busy,
  output logic                  out_valid,
  output logic signed [X_W-1:0] x_out,
  output logic                  converged,
  output logic [7:0]            iter_cnt
);

  // Six guard bits hold the worst-case weighted neighbour sum (41 * max|x|).
  localparam int SW = X_W + 6;
  localparam int IW = $clog2(N);
  localparam int OW = $clog2(N + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);
  localparam logic [OW-1:0] OUT_END  = OW'(N);
  localparam logic [7:0]    CS8      = 8'(CONV_SWEEPS);
  localparam logic [7:0]    MI8      = 8'(MAX_ITER);

  localparam logic signed [SW-1:0] C1     = SW'(1);
  localparam logic signed [SW-1:0] C6     = SW'(6);
  localparam logic signed [SW-1:0] C13    = SW'(13);
  localparam logic signed [SW-1:0] C20    = SW'(20);
  localparam logic signed [SW-1:0] TOL_W  = SW'(TOL);
  localparam logic signed [SW-1:0] XMAX_W = {{7{1'b0}}, {(X_W-1){1'b1}}};
  localparam logic signed [SW-1:0] XMIN_W = {{7{1'b1}}, {(X_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_SWEEP,
    S_CHECK,
    S_OUTPUT
  } state_t;

  state_t                state_q;
  logic [IW-1:0]         ld_idx_q;
  logic [IW-1:0]         sw_idx_q;
  logic [OW-1:0]         out_idx_q;
  logic [7:0]            iter_q;
  logic [7:0]            conv_run_q;
  logic                  sweep_ok_q;
  logic signed [X_W-1:0] x_q [N];
  logic signed [B_W-1:0] b_q [N];

  logic                  busy_q;
  logic                  out_valid_q;
  logic signed [X_W-1:0] x_out_q;
  logic                  converged_q;
  logic [7:0]            iter_cnt_q;

  // Datapath signals
  logic signed [X_W-1:0] nb [7];      // x[i-3] .. x[i+3], zero outside 0..N-1
  logic signed [B_W-1:0] b_sel;
  logic signed [X_W-1:0] x_sel;
  logic signed [X_W-1:0] ld_x_d;
  logic signed [SW-1:0]  bx_d;
  logic signed [SW-1:0]  s_d;
  logic signed [SW-1:0]  q_d;
  logic signed [SW-1:0]  r_d;
  logic signed [SW-1:0]  dlt_d;
  logic signed [SW-1:0]  absd_d;
  logic signed [X_W-1:0] x_new_d;
  logic                  ok_d;
  logic [7:0]            iter_d;
  logic [7:0]            conv_run_d;
  logic                  conv_hit_d;
  logic                  iter_hit_d;

  function automatic logic signed [SW-1:0] sx(input logic signed [X_W-1:0] v);
    return {{6{v[X_W-1]}}, v};
  endfunction

  // Element selection by decoded compare; out-of-range neighbours stay zero.
  always_comb begin
    b_sel = '0;
    x_sel = '0;
    for (int k = 0; k < 7; k++) nb[k] = '0;
    for (int j = 0; j < N; j++) begin
      if (sw_idx_q == IW'(j))  b_sel = b_q[j];
      if (out_idx_q == OW'(j)) x_sel = x_q[j];
      for (int k = 0; k < 7; k++) begin
        if (int'(sw_idx_q) + k - 3 == j) nb[k] = x_q[j];
      end
    end
  end

  // Load value: b sign-extended to X_W then scaled to the fixed-point grid.
  always_comb begin
    ld_x_d           = {X_W{b_in[B_W-1]}};
    ld_x_d[B_W-1:0]  = b_in;
    ld_x_d           = ld_x_d <<< FRAC;
  end

  // One Gauss-Seidel update per cycle. Signed division truncates toward
  // zero, so a negative inexact quotient is pulled down one to get floor.
  always_comb begin
    bx_d          = {SW{b_sel[B_W-1]}};
    bx_d[B_W-1:0] = b_sel;
    bx_d          = bx_d <<< FRAC;
    s_d = bx_d
        + C13 * (sx(nb[2]) + sx(nb[4]))
        - C6  * (sx(nb[1]) + sx(nb[5]))
        + sx(nb[0]) + sx(nb[6]);
    q_d = s_d / C20;
    r_d = s_d % C20;
    if (s_d[SW-1] && (r_d != '0)) q_d = q_d - C1;
    if (q_d > XMAX_W)      x_new_d = XMAX_W[X_W-1:0];
    else if (q_d < XMIN_W) x_new_d = XMIN_W[X_W-1:0];
    else                   x_new_d = q_d[X_W-1:0];
    dlt_d  = sx(x_new_d) - sx(nb[3]);
    absd_d = dlt_d[SW-1] ? -dlt_d : dlt_d;
    ok_d   = (absd_d <= TOL_W);
  end

  always_comb begin
    iter_d     = iter_q + 8'd1;
    conv_run_d = sweep_ok_q ? (conv_run_q + 8'd1) : 8'd0;
    conv_hit_d = (conv_run_d == CS8);
    iter_hit_d = (iter_d == MI8);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ld_idx_q    <= '0;
      sw_idx_q    <= '0;
      out_idx_q   <= '0;
      iter_q      <= '0;
      conv_run_q  <= '0;
      sweep_ok_q  <= 1'b0;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      x_out_q     <= '0;
      converged_q <= 1'b0;
      iter_cnt_q  <= '0;
      for (int j = 0; j < N; j++) begin
        x_q[j] <= '0;
        b_q[j] <= '0;
      end
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_en) begin
            b_q[ld_idx_q] <= b_in;
            x_q[ld_idx_q] <= ld_x_d;
            if (ld_idx_q == LAST_IDX) begin
              ld_idx_q   <= '0;
              sw_idx_q   <= '0;
              iter_q     <= '0;
              conv_run_q <= '0;
              busy_q     <= 1'b1;
              state_q    <= S_SWEEP;
            end else begin
              ld_idx_q <= ld_idx_q + 1'b1;
            end
          end
        end
        S_SWEEP: begin
          // In-place update: later unknowns in this sweep see new x[0..i-1].
          x_q[sw_idx_q] <= x_new_d;
          sweep_ok_q    <= (sw_idx_q == '0) ? ok_d : (sweep_ok_q & ok_d);
          if (sw_idx_q == LAST_IDX) begin
            sw_idx_q <= '0;
            state_q  <= S_CHECK;
          end else begin
            sw_idx_q <= sw_idx_q + 1'b1;
          end
        end
        S_CHECK: begin
          iter_q      <= iter_d;
          conv_run_q  <= conv_run_d;
          iter_cnt_q  <= iter_d;
          converged_q <= conv_hit_d;
          if (conv_hit_d || iter_hit_d) begin
            out_idx_q <= '0;
            state_q   <= S_OUTPUT;
          end else begin
            state_q <= S_SWEEP;
          end
        end
        S_OUTPUT: begin
          if (out_idx_q == OUT_END) begin
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= S_IDLE;
          end else begin
            out_valid_q <= 1'b1;
            x_out_q     <= x_sel;
            out_idx_q   <= out_idx_q + 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_q;
  assign out_valid = out_valid_q;
  assign x_out     = x_out_q;
  assign converged = converged_q;
  assign iter_cnt  = iter_cnt_q;

endmodule

// File: tb/tb_gsim_solver_param.sv
// tb/tb_gsim_solver_param.sv - self-checking bench for gsim_solver_param
module tb_gsim_solver_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic               in_en [3];
  logic signed [15:0] b_in  [3];
  logic               busy  [3];
  logic               ov    [3];
  logic               conv  [3];
  logic [7:0]         itc   [3];
  logic signed [31:0] xa;
  logic signed [31:0] xb;
  logic signed [23:0] xc;

  gsim_solver_param #(.N(16)) dut_a (
    .clk(clk), .reset(reset), .in_en(in_en[0]), .b_in(b_in[0]),
    .busy(busy[0]), .out_valid(ov[0]), .x_out(xa), .converged(conv[0]), .iter_cnt(itc[0])
  );

  gsim_solver_param #(.N(16), .MAX_ITER(3)) dut_b (
    .clk(clk), .reset(reset), .in_en(in_en[1]), .b_in(b_in[1]),
    .busy(busy[1]), .out_valid(ov[1]), .x_out(xb), .converged(conv[1]), .iter_cnt(itc[1])
  );

  gsim_solver_param #(.N(8), .FRAC(8), .X_W(24), .TOL(2)) dut_c (
    .clk(clk), .reset(reset), .in_en(in_en[2]), .b_in(b_in[2]),
    .busy(busy[2]), .out_valid(ov[2]), .x_out(xc), .converged(conv[2]), .iter_cnt(itc[2])
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int                 cur = 0;
  logic signed [63:0] oq [$];
  int                 first_cyc;
  int                 last_in;
  int                 unstable;
  int                 spurious = 0;
  int                 busyerr;
  logic               got_conv;
  logic [7:0]         got_iter;

  int     bvec [64];
  longint mx [64];
  int     m_conv;
  int     m_it;

  function automatic logic signed [63:0] xval(input int d);
    if (d == 0) return 64'(xa);
    else if (d == 1) return 64'(xb);
    else return 64'(xc);
  endfunction

  always @(negedge clk) begin
    for (int d = 0; d < 3; d++) if (ov[d] && d != cur) spurious++;
    if (ov[cur]) begin
      if (oq.size() == 0) begin
        first_cyc = cyc;
        got_conv  = conv[cur];
        got_iter  = itc[cur];
      end else if (conv[cur] !== got_conv || itc[cur] !== got_iter) begin
        unstable++;
      end
      if (busy[cur] !== 1'b1) busyerr++;
      oq.push_back(xval(cur));
    end
  end

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Reference: Gauss-Seidel sweeps with floor division and saturation,
  // stopping on consecutive tolerance sweeps or the sweep limit.
  task automatic model(input int n, input int frac, input int xw,
                       input int maxit, input int tol, input int cs);
    longint s, q, xmax, xmin, dlt, coef;
    int run;
    bit ok, done;
    xmax = (longint'(1) <<< (xw - 1)) - 1;
    xmin = -xmax - 1;
    for (int i = 0; i < n; i++) mx[i] = longint'(bvec[i]) * (longint'(1) <<< frac);
    m_it = 0; run = 0; m_conv = 0; done = 0;
    while (!done) begin
      ok = 1;
      for (int i = 0; i < n; i++) begin
        s = longint'(bvec[i]) * (longint'(1) <<< frac);
        for (int d = 1; d <= 3; d++) begin
          coef = (d == 1) ? 13 : ((d == 2) ? -6 : 1);
          if (i - d >= 0) s += coef * mx[i-d];
          if (i + d < n)  s += coef * mx[i+d];
        end
        q = s / 20;
        if ((s % 20) != 0 && s < 0) q--;
        if (q > xmax) q = xmax;
        if (q < xmin) q = xmin;
        dlt = q - mx[i];
        if (dlt < 0) dlt = -dlt;
        if (dlt > tol) ok = 0;
        mx[i] = q;
      end
      m_it++;
      run = ok ? run + 1 : 0;
      if (run == cs) begin m_conv = 1; done = 1; end
      else if (m_it == maxit) done = 1;
    end
  endtask

  task automatic load(input int d, input int n, input int g1, input int g2, input int glen);
    cur = d;
    oq.delete();
    unstable = 0;
    busyerr = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_en[d] = 1'b1;
      b_in[d]  = 16'(bvec[i]);
      if (i == g1 || i == g2) begin
        @(negedge clk);
        in_en[d] = 1'b0;
        b_in[d]  = 16'($urandom);
        repeat (glen - 1) @(negedge clk);
      end
    end
    @(negedge clk);
    last_in  = cyc;
    in_en[d] = 1'b0;
  endtask

  task automatic check_result(input int d, input int n, input int frac, input int xw,
                              input int maxit, input int tol, input int cs,
                              input string tag, input bit pulse);
    int w;
    logic signed [63:0] obs;
    model(n, frac, xw, maxit, tol, cs);
    w = 0;
    while (oq.size() == 0 && w < 3000) begin @(posedge clk); w++; end
    if (pulse && oq.size() > 0) begin
      // Strobes through the final output cycle must all be dropped.
      repeat (n - 1) begin
        @(negedge clk);
        in_en[d] = 1'b1;
        b_in[d]  = 16'($urandom);
      end
      @(negedge clk);
      in_en[d] = 1'b0;
    end
    while (oq.size() < n && w < 3000) begin @(posedge clk); w++; end
    repeat (4) @(posedge clk);
    chk({tag, " count"}, oq.size(), n);
    for (int i = 0; i < n; i++) begin
      obs = (i < oq.size()) ? oq[i] : 'x;
      chk($sformatf("%s x[%0d]", tag, i), obs, mx[i]);
    end
    chk({tag, " converged"}, got_conv, m_conv);
    chk({tag, " iter_cnt"}, got_iter, m_it);
    chk({tag, " latency"}, first_cyc - last_in, m_it * (n + 1) + 1);
    chk({tag, " status_stable"}, unstable, 0);
    chk({tag, " busy_in_output"}, busyerr, 0);
    chk({tag, " busy_after"}, busy[d], 1'b0);
    chk({tag, " out_valid_after"}, ov[d], 1'b0);
    chk({tag, " spurious"}, spurious, 0);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin in_en[d] = 1'b0; b_in[d] = '0; end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst busy", busy[0], 1'b0);
    chk("rst out_valid", ov[0], 1'b0);
    chk("rst x_out", xa, 0);
    chk("rst converged", conv[0], 1'b0);
    chk("rst iter_cnt", itc[0], 0);
    chk("rst c out_valid", ov[2], 1'b0);
    reset = 1'b0;

    // All-zero b
    for (int i = 0; i < 64; i++) bvec[i] = 0;
    load(0, 16, -1, -1, 0);
    check_result(0, 16, 16, 32, 80, 0, 2, "zero", 1'b0);

    // Ramp b
    for (int i = 0; i < 16; i++) bvec[i] = i * 100 - 800;
    load(0, 16, -1, -1, 0);
    check_result(0, 16, 16, 32, 80, 0, 2, "ramp", 1'b0);

    // Alternating full-scale b against a 3-sweep limit
    for (int i = 0; i < 16; i++) bvec[i] = (i % 2 == 0) ? 32767 : -32767;
    load(1, 16, -1, -1, 0);
    check_result(1, 16, 16, 32, 3, 0, 2, "alt", 1'b0);

    // Ramp with input gaps
    for (int i = 0; i < 16; i++) bvec[i] = i * 100 - 800;
    load(0, 16, 4, 11, 3);
    check_result(0, 16, 16, 32, 80, 0, 2, "gap", 1'b0);

    // Reset during the fifth sweep, then a clean ramp solve
    load(0, 16, -1, -1, 0);
    repeat (4 * 17 + 5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst busy", busy[0], 1'b0);
    chk("midrst out_valid", ov[0], 1'b0);
    chk("midrst x_out", xa, 0);
    chk("midrst converged", conv[0], 1'b0);
    chk("midrst iter_cnt", itc[0], 0);
    load(0, 16, -1, -1, 0);
    check_result(0, 16, 16, 32, 80, 0, 2, "postrst", 1'b0);

    // Narrow instance: random b, strobes during output, then next problem
    for (int p = 0; p < 3; p++) begin
      for (int i = 0; i < 8; i++) bvec[i] = $urandom_range(0, 65535) - 32768;
      load(2, 8, -1, -1, 0);
      check_result(2, 8, 8, 24, 80, 2, 2, $sformatf("narrow%0d", p), (p == 0));
    end

    // Default instance: random b with random gaps
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 16; i++) bvec[i] = $urandom_range(0, 65535) - 32768;
      load(0, 16, $urandom_range(0, 7), $urandom_range(8, 14), $urandom_range(1, 4));
      check_result(0, 16, 16, 32, 80, 0, 2, $sformatf("rand%0d", p), 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
